// File: rtl/cache_axi_bridge_pkg.sv
// Shared types and width helpers for the cache-to-AXI bridge.
// Holds the read/write FSM state encodings and the read-owner encoding.
package cache_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Byte-offset bits inside one cache line.
  function automatic int line_off_w(input int words, input int data_w);
    return $clog2(words * data_w / 8);
  endfunction

  function automatic int beat_cnt_w(input int iwords, input int dwords);
    return $clog2((iwords > dwords) ? iwords : dwords);
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Simplified AXI master port between the bridge and the AXI protocol converter.
// The bridge uses the master view; the converter (or a bench) uses the slave view.
interface cache_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rlast;
  logic [DATA_W-1:0] rdata;
  logic              rready;

  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                bvalid;

  modport master (
    output arvalid, araddr, arlen, rready,
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast,
    input  arready, rvalid, rlast, rdata,
    input  awready, wready, bvalid
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast,
    output arready, rvalid, rlast, rdata,
    output awready, wready, bvalid
  );

endinterface

// File: rtl/cache_axi_bridge_axi_line_writer.sv
// AXI write engine: captures one line writeback or single-word write and
// plays it out as an INCR burst, then waits for the write response.
module axi_line_writer
  import cache_axi_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DLINE_WORDS = 8,
  parameter int BCW         = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_wreq,
  input  logic                          i_wline,
  input  logic [ADDR_W-1:0]             i_waddr,
  input  logic [DLINE_WORDS*DATA_W-1:0] i_wdata,
  input  logic [DATA_W/8-1:0]           i_wstrb,
  output logic                          o_busy,
  output logic [ADDR_W-1:0]             o_waddr,
  output logic                          o_bvalid,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [ADDR_W-1:0]             o_awaddr,
  output logic [7:0]                    o_awlen,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  output logic [DATA_W-1:0]             o_wdata,
  output logic [DATA_W/8-1:0]           o_wstrb,
  output logic                          o_wlast,
  input  logic                          i_bvalid
);

  localparam int DOFF = line_off_w(DLINE_WORDS, DATA_W);
  localparam int WOFF = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LMASK = ~((ADDR_W'(1) << DOFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WMASK = ~((ADDR_W'(1) << WOFF) - ADDR_W'(1));

  wr_state_e                   r_wstate;
  logic [ADDR_W-1:0]           r_waddr;
  logic                        r_wline;
  logic [DATA_W/8-1:0]         r_wstrb;
  logic [DLINE_WORDS*DATA_W-1:0] r_wbuf;
  logic [BCW-1:0]              r_wcnt;
  logic                        r_bvalid;

  logic [7:0] w_awlen;
  logic       w_wlast;

  assign w_awlen = r_wline ? 8'(DLINE_WORDS - 1) : 8'd0;
  assign w_wlast = (8'(r_wcnt) == w_awlen);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_waddr  <= '0;
      r_wline  <= 1'b0;
      r_wstrb  <= '0;
      r_wbuf   <= '0;
      r_wcnt   <= '0;
      r_bvalid <= 1'b0;
    end else begin
      r_bvalid <= 1'b0;
      case (r_wstate)
        W_IDLE: begin
          if (i_wreq) begin
            // Line writebacks go out line-aligned, single words word-aligned.
            r_waddr  <= i_waddr & (i_wline ? LMASK : WMASK);
            r_wline  <= i_wline;
            r_wstrb  <= i_wline ? '1 : i_wstrb;
            r_wbuf   <= i_wdata;
            r_wcnt   <= '0;
            r_wstate <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (i_awready) r_wstate <= W_DATA;
        end
        W_DATA: begin
          if (i_wready) begin
            if (w_wlast) r_wstate <= W_RESP;
            else         r_wcnt   <= r_wcnt + 1'b1;
          end
        end
        W_RESP: begin
          if (i_bvalid) begin
            r_bvalid <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_wstate != W_IDLE);
  assign o_waddr   = r_waddr;
  assign o_bvalid  = r_bvalid;
  assign o_awvalid = (r_wstate == W_ADDR);
  assign o_awaddr  = r_waddr;
  assign o_awlen   = w_awlen;
  assign o_wvalid  = (r_wstate == W_DATA);
  assign o_wdata   = r_wbuf[r_wcnt*DATA_W +: DATA_W];
  assign o_wstrb   = r_wstrb;
  assign o_wlast   = w_wlast;

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridge between the L1 I/D caches and one AXI master port: refill read
// arbitration (DCache first), write engine, and read-after-write line hazard.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ILINE_WORDS = 8,
  parameter int DLINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inst_req_i,
  input  logic [ADDR_W-1:0]             inst_addr_i,
  output logic                          inst_rvalid_o,
  output logic [ILINE_WORDS*DATA_W-1:0] inst_rline_o,
  input  logic                          data_rreq_i,
  input  logic                          data_rline_i,
  input  logic [ADDR_W-1:0]             data_raddr_i,
  output logic                          data_rvalid_o,
  output logic [DATA_W-1:0]             data_rdata_o,
  output logic                          data_rlast_o,
  input  logic                          data_wreq_i,
  input  logic                          data_wline_i,
  input  logic [ADDR_W-1:0]             data_waddr_i,
  input  logic [DLINE_WORDS*DATA_W-1:0] data_wdata_i,
  input  logic [DATA_W/8-1:0]           data_wstrb_i,
  output logic                          data_bvalid_o,
  output logic                          data_stall_o,
  cache_axi_bridge_if.master            axi
);

  localparam int IOFF = line_off_w(ILINE_WORDS, DATA_W);
  localparam int DOFF = line_off_w(DLINE_WORDS, DATA_W);
  localparam int WOFF = $clog2(DATA_W / 8);
  localparam int BCW  = beat_cnt_w(ILINE_WORDS, DLINE_WORDS);
  localparam logic [ADDR_W-1:0] IMASK = ~((ADDR_W'(1) << IOFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] DMASK = ~((ADDR_W'(1) << DOFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WMASK = ~((ADDR_W'(1) << WOFF) - ADDR_W'(1));

  rd_state_e                     r_rstate;
  owner_e                        r_owner;
  logic [BCW-1:0]                r_beat_cnt;
  logic [ADDR_W-1:0]             r_araddr;
  logic [7:0]                    r_arlen;
  logic [ILINE_WORDS*DATA_W-1:0] r_inst_rline;
  logic                          r_inst_rvalid;

  logic              w_wr_busy;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_accept;
  logic              w_hazard;
  logic              w_d_go;
  logic              w_i_go;

  // A write accepted this cycle is registered before the read is compared
  // against it, so a same-cycle read waits one cycle for the hazard check.
  assign w_wr_accept = data_wreq_i & ~w_wr_busy;
  assign w_hazard    = w_wr_busy & ((data_raddr_i >> DOFF) == (w_wr_addr >> DOFF));
  assign w_d_go      = data_rreq_i & ~w_hazard & ~w_wr_accept;
  // inst_req_i is still high in the cycle inst_rvalid_o pulses.
  assign w_i_go      = inst_req_i & ~r_inst_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate      <= R_IDLE;
      r_owner       <= OWN_I;
      r_beat_cnt    <= '0;
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_inst_rline  <= '0;
      r_inst_rvalid <= 1'b0;
    end else begin
      r_inst_rvalid <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          r_beat_cnt <= '0;
          if (w_d_go) begin
            r_owner  <= OWN_D;
            r_araddr <= data_raddr_i & (data_rline_i ? DMASK : WMASK);
            r_arlen  <= data_rline_i ? 8'(DLINE_WORDS - 1) : 8'd0;
            r_rstate <= R_ADDR;
          end else if (w_i_go) begin
            r_owner  <= OWN_I;
            r_araddr <= inst_addr_i & IMASK;
            r_arlen  <= 8'(ILINE_WORDS - 1);
            r_rstate <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (axi.arready) r_rstate <= R_DATA;
        end
        R_DATA: begin
          if (axi.rvalid) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (r_owner == OWN_I) r_inst_rline[r_beat_cnt*DATA_W +: DATA_W] <= axi.rdata;
            if (axi.rlast) begin
              r_rstate      <= R_IDLE;
              r_inst_rvalid <= (r_owner == OWN_I);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign axi.arvalid = (r_rstate == R_ADDR);
  assign axi.araddr  = r_araddr;
  assign axi.arlen   = r_arlen;
  assign axi.rready  = (r_rstate == R_DATA);

  assign inst_rvalid_o = r_inst_rvalid;
  assign inst_rline_o  = r_inst_rline;

  assign data_rvalid_o = axi.rvalid & (r_owner == OWN_D) & (r_rstate == R_DATA);
  assign data_rlast_o  = data_rvalid_o & axi.rlast;
  assign data_rdata_o  = axi.rdata;
  assign data_stall_o  = (data_rreq_i & ~data_rlast_o) | (data_wreq_i & w_wr_busy);

  logic              w_awvalid;
  logic [ADDR_W-1:0] w_awaddr;
  logic [7:0]        w_awlen;
  logic              w_wvalid;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  logic              w_wlast;

  axi_line_writer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DLINE_WORDS (DLINE_WORDS),
    .BCW         (BCW)
  ) u_writer (
    .clk       (clk),
    .rst       (rst),
    .i_wreq    (data_wreq_i),
    .i_wline   (data_wline_i),
    .i_waddr   (data_waddr_i),
    .i_wdata   (data_wdata_i),
    .i_wstrb   (data_wstrb_i),
    .o_busy    (w_wr_busy),
    .o_waddr   (w_wr_addr),
    .o_bvalid  (data_bvalid_o),
    .o_awvalid (w_awvalid),
    .i_awready (axi.awready),
    .o_awaddr  (w_awaddr),
    .o_awlen   (w_awlen),
    .o_wvalid  (w_wvalid),
    .i_wready  (axi.wready),
    .o_wdata   (w_wdata),
    .o_wstrb   (w_wstrb),
    .o_wlast   (w_wlast),
    .i_bvalid  (axi.bvalid)
  );

  assign axi.awvalid = w_awvalid;
  assign axi.awaddr  = w_awaddr;
  assign axi.awlen   = w_awlen;
  assign axi.wvalid  = w_wvalid;
  assign axi.wdata   = w_wdata;
  assign axi.wstrb   = w_wstrb;
  assign axi.wlast   = w_wlast;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: refills, arbitration, writeback, hazard, reset.
module tb_cache_axi_bridge;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IW     = 8;
  localparam int DW     = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 inst_req_i;
  logic [ADDR_W-1:0]    inst_addr_i;
  logic                 inst_rvalid_o;
  logic [IW*DATA_W-1:0] inst_rline_o;
  logic                 data_rreq_i;
  logic                 data_rline_i;
  logic [ADDR_W-1:0]    data_raddr_i;
  logic                 data_rvalid_o;
  logic [DATA_W-1:0]    data_rdata_o;
  logic                 data_rlast_o;
  logic                 data_wreq_i;
  logic                 data_wline_i;
  logic [ADDR_W-1:0]    data_waddr_i;
  logic [DW*DATA_W-1:0] data_wdata_i;
  logic [DATA_W/8-1:0]  data_wstrb_i;
  logic                 data_bvalid_o;
  logic                 data_stall_o;

  cache_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  cache_axi_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ILINE_WORDS(IW), .DLINE_WORDS(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req_i    (inst_req_i),
    .inst_addr_i   (inst_addr_i),
    .inst_rvalid_o (inst_rvalid_o),
    .inst_rline_o  (inst_rline_o),
    .data_rreq_i   (data_rreq_i),
    .data_rline_i  (data_rline_i),
    .data_raddr_i  (data_raddr_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_rlast_o  (data_rlast_o),
    .data_wreq_i   (data_wreq_i),
    .data_wline_i  (data_wline_i),
    .data_waddr_i  (data_waddr_i),
    .data_wdata_i  (data_wdata_i),
    .data_wstrb_i  (data_wstrb_i),
    .data_bvalid_o (data_bvalid_o),
    .data_stall_o  (data_stall_o),
    .axi           (axi)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!axi.arvalid && n < 20);
    chk({tag, "_arvalid"}, axi.arvalid, 1);
  endtask

  task automatic serve_read(input string tag, input logic [31:0] base, input int n, input bit own_d);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk({tag, "_rready"}, axi.rready, 1);
    for (int k = 0; k < n; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = base + k;
      axi.rlast  = (k == n - 1);
      #1;
      chk({tag, "_drvalid"}, data_rvalid_o, own_d);
      chk({tag, "_drlast"}, data_rlast_o, own_d && (k == n - 1));
      if (own_d) begin
        chk({tag, "_drdata"}, data_rdata_o, base + k);
        chk({tag, "_dstall"}, data_stall_o, k != n - 1);
      end else begin
        chk({tag, "_irv_early"}, inst_rvalid_o, 0);
      end
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic chk_iline(input string tag, input logic [31:0] base);
    logic [IW*DATA_W-1:0] exp;
    for (int k = 0; k < IW; k++) exp[k*DATA_W +: DATA_W] = base + k;
    chk({tag, "_irvalid"}, inst_rvalid_o, 1);
    chk({tag, "_iline"}, inst_rline_o, exp);
  endtask

  task automatic drain_write(input int n);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    axi.wready  = 1'b1;
    repeat (n) tick();
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b1;
    tick();
    axi.bvalid  = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int cyc;
    rst = 1'b1;
    inst_req_i = 0; inst_addr_i = '0;
    data_rreq_i = 0; data_rline_i = 0; data_raddr_i = '0;
    data_wreq_i = 0; data_wline_i = 0; data_waddr_i = '0; data_wdata_i = '0; data_wstrb_i = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rdata = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    repeat (3) tick();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_irvalid", inst_rvalid_o, 0);
    chk("rst_iline", inst_rline_o, 0);
    chk("rst_bvalid", data_bvalid_o, 0);
    chk("rst_stall", data_stall_o, 0);
    rst = 1'b0;
    tick();

    // ICache refill, offset address
    inst_req_i = 1; inst_addr_i = 32'h1000_0024;
    wait_ar("ic");
    chk("ic_araddr", axi.araddr, 32'h1000_0020);
    chk("ic_arlen", axi.arlen, 7);
    serve_read("ic", 32'hA0, 8, 0);
    chk_iline("ic", 32'hA0);
    chk("ic_word0", inst_rline_o[31:0], 32'hA0);
    inst_req_i = 0;
    tick();
    chk("ic_pulse_end", inst_rvalid_o, 0);
    chk("ic_no_rerun", axi.arvalid, 0);

    // Data single word wins over simultaneous ICache request
    inst_req_i = 1; inst_addr_i = 32'h1000_0100;
    data_rreq_i = 1; data_rline_i = 0; data_raddr_i = 32'h8000_0004;
    #1;
    chk("arb_stall", data_stall_o, 1);
    wait_ar("arb_d");
    chk("arb_d_araddr", axi.araddr, 32'h8000_0004);
    chk("arb_d_arlen", axi.arlen, 0);
    serve_read("arb_d", 32'hD0, 1, 1);
    data_rreq_i = 0;
    wait_ar("arb_i");
    chk("arb_i_araddr", axi.araddr, 32'h1000_0100);
    chk("arb_i_arlen", axi.arlen, 7);
    serve_read("arb_i", 32'hB0, 8, 0);
    chk_iline("arb_i", 32'hB0);
    inst_req_i = 0;
    tick();

    // Line writeback with wready toggling
    data_wreq_i = 1; data_wline_i = 1; data_waddr_i = 32'h2000_0040; data_wstrb_i = 4'h0;
    for (int i = 0; i < DW; i++) data_wdata_i[i*DATA_W +: DATA_W] = 32'hC0 + i;
    tick();
    data_wreq_i = 0;
    chk("wb_awvalid", axi.awvalid, 1);
    chk("wb_awaddr", axi.awaddr, 32'h2000_0040);
    chk("wb_awlen", axi.awlen, 7);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      axi.wready = cyc[0];
      if (axi.wready) begin
        chk("wb_wvalid", axi.wvalid, 1);
        chk("wb_wdata", axi.wdata, 32'hC0 + k);
        chk("wb_wlast", axi.wlast, k == 7);
        chk("wb_wstrb", axi.wstrb, 4'hF);
        k++;
      end
      tick();
      cyc++;
    end
    axi.wready = 0;
    chk("wb_beats", k, 8);
    chk("wb_wvalid_done", axi.wvalid, 0);
    chk("wb_bvalid_wait", data_bvalid_o, 0);
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;
    chk("wb_bvalid", data_bvalid_o, 1);
    tick();
    chk("wb_bvalid_end", data_bvalid_o, 0);

    // RAW hazard on the same line
    data_wreq_i = 1; data_wline_i = 1; data_waddr_i = 32'h2000_0040;
    tick();
    data_wreq_i = 0;
    data_rreq_i = 1; data_rline_i = 1; data_raddr_i = 32'h2000_0048;
    #1;
    chk("haz_stall", data_stall_o, 1);
    repeat (3) tick();
    chk("haz_hold_addr", axi.arvalid, 0);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    axi.wready = 1;
    repeat (8) tick();
    axi.wready = 0;
    chk("haz_hold_resp", axi.arvalid, 0);
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;
    chk("haz_bvalid", data_bvalid_o, 1);
    chk("haz_hold_bv", axi.arvalid, 0);
    tick();
    chk("haz_release", axi.arvalid, 1);
    chk("haz_araddr", axi.araddr, 32'h2000_0040);
    chk("haz_arlen", axi.arlen, 7);
    serve_read("haz", 32'hE0, 8, 1);
    data_rreq_i = 0;

    // Different line proceeds while the write is pending
    data_wreq_i = 1; data_wline_i = 1; data_waddr_i = 32'h2000_0040;
    tick();
    data_wreq_i = 0;
    data_rreq_i = 1; data_rline_i = 0; data_raddr_i = 32'h3000_0000;
    tick();
    chk("nohaz_arvalid", axi.arvalid, 1);
    chk("nohaz_araddr", axi.araddr, 32'h3000_0000);
    chk("nohaz_arlen", axi.arlen, 0);
    chk("nohaz_wpend", axi.awvalid, 1);
    serve_read("nohaz", 32'hF0, 1, 1);
    data_rreq_i = 0;
    drain_write(8);

    // Single-word write, second request while busy
    data_wreq_i = 1; data_wline_i = 0; data_waddr_i = 32'h4000_0006; data_wstrb_i = 4'b0011;
    data_wdata_i = '0;
    data_wdata_i[31:0] = 32'h1234_5678;
    tick();
    data_wreq_i = 0;
    chk("sw_awaddr", axi.awaddr, 32'h4000_0004);
    chk("sw_awlen", axi.awlen, 0);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    chk("sw_wvalid", axi.wvalid, 1);
    chk("sw_wlast", axi.wlast, 1);
    chk("sw_wstrb", axi.wstrb, 4'b0011);
    chk("sw_wdata", axi.wdata, 32'h1234_5678);
    data_wreq_i = 1; data_waddr_i = 32'h5000_0000;
    #1;
    chk("sw_stall_data", data_stall_o, 1);
    axi.wready = 1;
    tick();
    axi.wready = 0;
    #1;
    chk("sw_stall_resp", data_stall_o, 1);
    chk("sw_wvalid_done", axi.wvalid, 0);
    data_wreq_i = 0;
    axi.bvalid = 1;
    tick();
    axi.bvalid = 0;
    chk("sw_bvalid", data_bvalid_o, 1);
    chk("sw_no_second", axi.awvalid, 0);
    tick();
    chk("sw_bvalid_end", data_bvalid_o, 0);

    // Reset during beat 3 of an ICache refill
    inst_req_i = 1; inst_addr_i = 32'h1000_0200;
    wait_ar("rst1");
    axi.arready = 1;
    tick();
    axi.arready = 0;
    for (int i = 0; i < 3; i++) begin
      axi.rvalid = 1; axi.rlast = 0; axi.rdata = 32'h60 + i;
      tick();
    end
    axi.rdata = 32'h63;
    rst = 1;
    tick();
    rst = 0;
    axi.rvalid = 0;
    chk("mrst_arvalid", axi.arvalid, 0);
    chk("mrst_rready", axi.rready, 0);
    chk("mrst_irvalid", inst_rvalid_o, 0);
    chk("mrst_iline", inst_rline_o, 0);
    tick();
    chk("mrst_irvalid2", inst_rvalid_o, 0);
    chk("mrst_arvalid2", axi.arvalid, 1);
    chk("mrst_araddr", axi.araddr, 32'h1000_0200);
    serve_read("mrst", 32'h70, 8, 0);
    chk_iline("mrst", 32'h70);
    inst_req_i = 0;
    tick();
    chk("mrst_pulse_end", inst_rvalid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
